// File: rtl/operand_memory_if.sv
// Handshake and serial operand lines between operand_memory and the arithmetic unit.
`timescale 1ns/1ps
interface operand_memory_if;
  logic dataready;
  logic stop;
  logic num1_bit;
  logic num2_bit;
  logic select0;
  logic select1;
  logic ok;

  modport master (
    input  dataready, stop,
    output num1_bit, num2_bit, select0, select1, ok
  );

  modport slave (
    output dataready, stop,
    input  num1_bit, num2_bit, select0, select1, ok
  );
endinterface

// File: rtl/operand_memory.sv
// Operand ROM: streams two fixed FP32 operands MSB first and presents the op code,
// then holds ok until the consumer acknowledges with stop.
`timescale 1ns/1ps
module operand_memory #(
  parameter int NUM_SETS = 4,
  parameter int WIDTH    = 32
) (
  input  logic                clk,
  input  logic                reset,
  operand_memory_if.master    bus
);

  localparam int IDX_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic [1:0]       op;
  } entry_t;

  // Only four distinct entries exist; larger NUM_SETS repeats them.
  function automatic entry_t rom(input logic [IDX_W-1:0] i);
    entry_t e;
    e = '0;
    case (int'(i) % 4)
      0:       e = '{num1: WIDTH'(32'h3F80_0000), num2: WIDTH'(32'h4000_0000), op: 2'b00};
      1:       e = '{num1: WIDTH'(32'h4040_0000), num2: WIDTH'(32'h3F00_0000), op: 2'b01};
      2:       e = '{num1: WIDTH'(32'h40A0_0000), num2: WIDTH'(32'hC000_0000), op: 2'b10};
      3:       e = '{num1: WIDTH'(32'h4120_0000), num2: WIDTH'(32'h4080_0000), op: 2'b11};
      default: e = '0;
    endcase
    return e;
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             num1_q, num1_d;
  logic             num2_q, num2_d;
  logic [1:0]       sel_q, sel_d;
  logic             ok_q, ok_d;
  entry_t           cur;

  // Registered outputs: the comb block computes what appears after the next edge.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    num1_d  = 1'b0;
    num2_d  = 1'b0;
    sel_d   = 2'b00;
    ok_d    = 1'b0;
    cur     = rom(idx_q);

    case (state_q)
      IDLE: begin
        if (bus.dataready) begin
          state_d = SEND;
          cnt_d   = CNT_W'(WIDTH - 1);
          num1_d  = cur.num1[WIDTH-1];
          num2_d  = cur.num2[WIDTH-1];
          sel_d   = cur.op;
        end
      end
      SEND: begin
        sel_d = cur.op;
        if (cnt_q == '0) begin
          state_d = DONE;
          ok_d    = 1'b1;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          num1_d = cur.num1[cnt_d];
          num2_d = cur.num2[cnt_d];
        end
      end
      DONE: begin
        if (bus.stop) begin
          state_d = IDLE;
          idx_d   = (idx_q == IDX_W'(NUM_SETS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
          ok_d  = 1'b1;
          sel_d = cur.op;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      num1_q  <= 1'b0;
      num2_q  <= 1'b0;
      sel_q   <= 2'b00;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      sel_q   <= sel_d;
      ok_q    <= ok_d;
    end
  end

  assign bus.num1_bit = num1_q;
  assign bus.num2_bit = num2_q;
  assign bus.select0  = sel_q[0];
  assign bus.select1  = sel_q[1];
  assign bus.ok       = ok_q;

endmodule

// File: tb/tb_operand_memory.sv
// Directed bench for operand_memory: streams every ROM set, wrap-around,
// ignored requests/acks during transfer, held request, and mid-transfer reset.
`timescale 1ns/1ps
module tb_operand_memory;

  logic clk = 1'b0;
  logic reset;
  operand_memory_if bus ();

  operand_memory #(.NUM_SETS(4), .WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_n1 [4] = '{32'h3F80_0000, 32'h4040_0000, 32'h40A0_0000, 32'h4120_0000};
  logic [31:0] exp_n2 [4] = '{32'h4000_0000, 32'h3F00_0000, 32'hC000_0000, 32'h4080_0000};
  logic [1:0]  exp_op [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check(tag, {27'b0, bus.ok, bus.select1, bus.select0, bus.num1_bit, bus.num2_bit}, 32'h0);
  endtask

  // One request/acknowledge round for ROM set s.
  task automatic run_set(input int s, input int hold, input bit disturb, input bit both_ack);
    logic [31:0] w1, w2;
    string tag;
    tag = $sformatf("set%0d", s);
    w1 = '0;
    w2 = '0;
    bus.dataready = 1'b1;
    tick;
    for (int k = 0; k < 32; k++) begin
      w1 = {w1[30:0], bus.num1_bit};
      w2 = {w2[30:0], bus.num2_bit};
      check({tag, "_sel_ok"}, {29'b0, bus.ok, bus.select1, bus.select0}, {29'b0, 1'b0, exp_op[s]});
      bus.dataready = (k < hold - 1) || (disturb && k == 5);
      bus.stop      = disturb && (k == 10);
      tick;
    end
    bus.dataready = 1'b0;
    bus.stop      = 1'b0;
    check({tag, "_num1"}, w1, exp_n1[s]);
    check({tag, "_num2"}, w2, exp_n2[s]);
    check({tag, "_num2_sign"}, {31'b0, w2[31]}, {31'b0, exp_n2[s][31]});
    for (int h = 0; h < 3; h++) begin
      check({tag, "_done"}, {27'b0, bus.ok, bus.select1, bus.select0, bus.num1_bit, bus.num2_bit},
            {27'b0, 1'b1, exp_op[s], 2'b00});
      tick;
    end
    bus.stop      = 1'b1;
    bus.dataready = both_ack;
    tick;
    bus.stop      = 1'b0;
    bus.dataready = 1'b0;
    check_idle({tag, "_ack"});
    for (int h = 0; h < 3; h++) begin
      tick;
      check_idle({tag, "_post_idle"});
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.dataready = 1'b0;
    bus.stop      = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    check_idle("reset");
    for (int i = 0; i < 5; i++) begin
      tick;
      check_idle("idle");
    end

    run_set(0, 1, 1'b0, 1'b0);
    run_set(1, 1, 1'b0, 1'b0);
    run_set(2, 1, 1'b0, 1'b0);
    run_set(3, 1, 1'b0, 1'b0);
    run_set(0, 1, 1'b1, 1'b0);   // wrap, with stray request and ack mid-stream
    run_set(1, 3, 1'b0, 1'b0);   // request held three cycles
    run_set(2, 1, 1'b0, 1'b1);   // stop and dataready together in DONE
    run_set(3, 1, 1'b0, 1'b0);
    run_set(0, 1, 1'b0, 1'b0);

    // Set 1 aborted by reset while bit 10 is on the lines.
    bus.dataready = 1'b1;
    tick;
    bus.dataready = 1'b0;
    for (int i = 0; i < 21; i++) tick;
    check("abort_bit10", {29'b0, bus.select1, bus.select0, bus.num1_bit, bus.num2_bit},
          {29'b0, exp_op[1], exp_n1[1][10], exp_n2[1][10]});
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_idle("abort_reset");
    tick;
    check_idle("abort_idle");
    run_set(0, 1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
